tdc_readout_buffer: RTL and testbench
=====================================

TDC_READOUT_BUFFER -- requirements
Module: tdc_readout_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, buffer depth in 32-bit words; power of two, minimum 4.
REQ-002 SHALL have parameter DATA_IDENTIFIER, default 4'b0100, expected value of bits [31:28] of each TDC word.
REQ-003 SHALL have parameter CHECK_ID, default 1; 1 = discard words with a wrong identifier, 0 = accept all words.
REQ-004 SHALL have port BUS_CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port BUS_RST, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port ENABLE, input, 1, permits pulling words from upstream.
REQ-007 SHALL have port CLEAR, input, 1, synchronous flush of buffer and counters.
REQ-008 SHALL have port IN_FIFO_EMPTY, input, 1, upstream TDC FIFO empty flag.
REQ-009 SHALL have port IN_FIFO_DATA, input, 32, upstream head word; valid whenever IN_FIFO_EMPTY=0 (first-word-fall-through).
REQ-010 SHALL have port IN_FIFO_READ, output, 1, pops the upstream word in the same cycle.
REQ-011 SHALL have port OUT_FIFO_READ, input, 1, downstream pop request.
REQ-012 SHALL have port OUT_FIFO_EMPTY, output, 1, buffer empty flag.
REQ-013 SHALL have port OUT_FIFO_DATA, output, 32, buffer head word; first-word-fall-through.
REQ-014 SHALL have port FULL, output, 1, high when buffer holds DEPTH words.
REQ-015 SHALL have port WORD_CNT, output, 32, count of words written into the buffer.
REQ-016 SHALL have port ID_ERR_CNT, output, 8, count of words discarded for a wrong identifier.

Function
REQ-017 SHALL drive IN_FIFO_READ combinationally as ENABLE & ~IN_FIFO_EMPTY & ~FULL & ~CLEAR & ~BUS_RST.
REQ-018 SHALL, on each cycle with IN_FIFO_READ=1, write IN_FIFO_DATA at the write pointer if CHECK_ID=0 or IN_FIFO_DATA[31:28]=DATA_IDENTIFIER.
REQ-019 SHALL otherwise pop and drop the word, not change occupancy, and increment ID_ERR_CNT, saturating at 255.
REQ-020 SHALL increment WORD_CNT by 1 per written word, wrapping from 2^32-1 to 0.
REQ-021 SHALL keep occupancy in a log2(DEPTH)+1-bit counter; read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 SHALL assert OUT_FIFO_EMPTY exactly when occupancy = 0 and FULL exactly when occupancy = DEPTH, both registered-state derived.
REQ-023 SHALL present mem[read pointer] on OUT_FIFO_DATA whenever OUT_FIFO_EMPTY=0; the value while empty is don't-care.
REQ-024 SHALL advance the read pointer on OUT_FIFO_READ=1 with OUT_FIFO_EMPTY=0, and ignore OUT_FIFO_READ while empty.
REQ-025 SHALL, on a simultaneous write and read, leave occupancy unchanged and advance both pointers.
REQ-026 SHALL, when full, not accept input even if OUT_FIFO_READ=1 in the same cycle; there is no bypass path.
REQ-027 SHALL give a write-to-output latency of 1 cycle: a word written at edge N is visible on OUT_FIFO_DATA after edge N if the buffer was empty.
REQ-028 SHALL, on ENABLE=0, stop pulling input while downstream reads continue to drain buffered words.
REQ-029 SHALL, on CLEAR=1, zero pointers, occupancy, WORD_CNT and ID_ERR_CNT at the next edge; CLEAR has priority over simultaneous reads and writes.

Reset
REQ-030 SHALL, while BUS_RST=1, asynchronously zero pointers, occupancy, WORD_CNT and ID_ERR_CNT, giving OUT_FIFO_EMPTY=1, FULL=0 and IN_FIFO_READ=0.
REQ-031 SHALL discard buffered contents when reset is asserted mid-operation, and restart empty after release.
REQ-032 SHALL not initialise memory contents on reset.

Verification
REQ-033 SHALL test basic flow: ENABLE=1, upstream supplies 0x4000_0001..0x4000_0003, downstream reads each cycle -> words out in order, WORD_CNT=3, ID_ERR_CNT=0.
REQ-034 SHALL test ID filter: words 0x4000_0010, 0x5000_0011, 0x4000_0012 with CHECK_ID=1 -> output 0x4000_0010 then 0x4000_0012, ID_ERR_CNT=1, WORD_CNT=2.
REQ-035 SHALL test full: no downstream reads, 20 upstream words, DEPTH=16 -> FULL=1 after 16 writes, IN_FIFO_READ=0 thereafter; one read with words pending -> refill on the following cycle only.
REQ-036 SHALL test wrap: 40 words streamed with alternating read stalls -> all 40 out in order, pointers wrap twice, WORD_CNT=40.
REQ-037 SHALL test CLEAR and reset: CLEAR while occupancy=5 -> OUT_FIFO_EMPTY=1 and counters 0 next cycle; BUS_RST mid-stream -> IN_FIFO_READ=0 immediately and empty after release.
REQ-038 SHALL test saturation: 300 bad-ID words -> ID_ERR_CNT=255 and the buffer stays empty.

Source files
------------

// File: rtl/tdc_readout_buffer.sv
// First-word-fall-through buffer between an upstream TDC FIFO and a downstream reader.
// Optionally drops words whose identifier nibble does not match, counting them.
module tdc_readout_buffer #(
  parameter int          DEPTH           = 16,
  parameter logic [3:0]  DATA_IDENTIFIER = 4'b0100,
  parameter bit          CHECK_ID        = 1'b1
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic        CLEAR,
  input  logic        IN_FIFO_EMPTY,
  input  logic [31:0] IN_FIFO_DATA,
  output logic        IN_FIFO_READ,
  input  logic        OUT_FIFO_READ,
  output logic        OUT_FIFO_EMPTY,
  output logic [31:0] OUT_FIFO_DATA,
  output logic        FULL,
  output logic [31:0] WORD_CNT,
  output logic [7:0]  ID_ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [31:0]   r_wordCnt;
  logic [7:0]    r_idErrCnt;

  logic w_idOk;
  logic w_write;
  logic w_drop;
  logic w_read;

  assign OUT_FIFO_EMPTY = (r_count == '0);
  assign FULL           = (r_count == CNT_FULL);
  assign OUT_FIFO_DATA  = r_mem[r_rdPtr];
  assign WORD_CNT       = r_wordCnt;
  assign ID_ERR_CNT     = r_idErrCnt;

  assign IN_FIFO_READ = ENABLE & ~IN_FIFO_EMPTY & ~FULL & ~CLEAR & ~BUS_RST;
  assign w_idOk       = (CHECK_ID == 1'b0) || (IN_FIFO_DATA[31:28] == DATA_IDENTIFIER);
  assign w_write      = IN_FIFO_READ & w_idOk;
  assign w_drop       = IN_FIFO_READ & ~w_idOk;
  assign w_read       = OUT_FIFO_READ & ~OUT_FIFO_EMPTY & ~CLEAR;

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge BUS_CLK) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= IN_FIFO_DATA;
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_wordCnt  <= '0;
      r_idErrCnt <= '0;
    end else if (CLEAR) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_wordCnt  <= '0;
      r_idErrCnt <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr   <= r_wrPtr + PTR_ONE;
        r_wordCnt <= r_wordCnt + 32'd1;
      end
      if (w_read) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      if (w_drop && (r_idErrCnt != 8'hFF)) begin
        r_idErrCnt <= r_idErrCnt + 8'd1;
      end
      // Simultaneous write and read leaves occupancy unchanged.
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_readout_buffer.sv
// Directed bench: a queue models the upstream FWFT FIFO, a second queue holds the
// words the buffer should emit; checks are immediate assertions.
module tb_tdc_readout_buffer;

  logic        BUS_CLK;
  logic        BUS_RST;
  logic        ENABLE;
  logic        CLEAR;
  logic        IN_FIFO_EMPTY;
  logic [31:0] IN_FIFO_DATA;
  logic        IN_FIFO_READ;
  logic        OUT_FIFO_READ;
  logic        OUT_FIFO_EMPTY;
  logic [31:0] OUT_FIFO_DATA;
  logic        FULL;
  logic [31:0] WORD_CNT;
  logic [7:0]  ID_ERR_CNT;

  int checkCount = 0;
  int failCount  = 0;
  int outSeen    = 0;
  logic [31:0] upQ[$];
  logic [31:0] expQ[$];

  tdc_readout_buffer #(
    .DEPTH(16),
    .DATA_IDENTIFIER(4'b0100),
    .CHECK_ID(1'b1)
  ) dut (
    .BUS_CLK(BUS_CLK),
    .BUS_RST(BUS_RST),
    .ENABLE(ENABLE),
    .CLEAR(CLEAR),
    .IN_FIFO_EMPTY(IN_FIFO_EMPTY),
    .IN_FIFO_DATA(IN_FIFO_DATA),
    .IN_FIFO_READ(IN_FIFO_READ),
    .OUT_FIFO_READ(OUT_FIFO_READ),
    .OUT_FIFO_EMPTY(OUT_FIFO_EMPTY),
    .OUT_FIFO_DATA(OUT_FIFO_DATA),
    .FULL(FULL),
    .WORD_CNT(WORD_CNT),
    .ID_ERR_CNT(ID_ERR_CNT)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic refreshUp();
    IN_FIFO_EMPTY = (upQ.size() == 0);
    IN_FIFO_DATA  = (upQ.size() != 0) ? upQ[0] : 32'h0;
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    upQ.push_back(word);
    refreshUp();
  endtask

  // One clock cycle: check flags and popped data at the negedge, update models after the edge.
  task automatic tick();
    logic pop;
    logic rd;
    logic expPop;
    logic [31:0] din;
    logic [31:0] want;
    @(negedge BUS_CLK);
    checkOutput("empty_flag", {31'b0, OUT_FIFO_EMPTY}, {31'b0, expQ.size() == 0});
    checkOutput("full_flag", {31'b0, FULL}, {31'b0, expQ.size() == 16});
    expPop = ENABLE && (upQ.size() != 0) && (expQ.size() != 16) && !CLEAR && !BUS_RST;
    checkOutput("in_read", {31'b0, IN_FIFO_READ}, {31'b0, expPop});
    pop = IN_FIFO_READ;
    din = IN_FIFO_DATA;
    rd  = OUT_FIFO_READ && (expQ.size() != 0) && !CLEAR && !BUS_RST;
    if (rd) begin
      want = expQ.pop_front();
      checkOutput("dout", OUT_FIFO_DATA, want);
      outSeen++;
    end
    @(posedge BUS_CLK);
    #1;
    if (CLEAR || BUS_RST) begin
      expQ.delete();
    end else if (pop && din[31:28] == 4'b0100) begin
      expQ.push_back(din);
    end
    if (pop && upQ.size() != 0) void'(upQ.pop_front());
    refreshUp();
  endtask

  task automatic doClear();
    upQ.delete();
    refreshUp();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  initial begin
    BUS_RST = 1'b1;
    ENABLE = 1'b0;
    CLEAR = 1'b0;
    OUT_FIFO_READ = 1'b0;
    refreshUp();
    #3;
    checkOutput("rst_empty", {31'b0, OUT_FIFO_EMPTY}, 32'd1);
    checkOutput("rst_full", {31'b0, FULL}, 32'd0);
    checkOutput("rst_in_read", {31'b0, IN_FIFO_READ}, 32'd0);
    checkOutput("rst_word_cnt", WORD_CNT, 32'd0);
    checkOutput("rst_err_cnt", {24'b0, ID_ERR_CNT}, 32'd0);
    tick();
    BUS_RST = 1'b0;
    tick();

    $display("[TB] basic flow");
    ENABLE = 1'b1;
    OUT_FIFO_READ = 1'b1;
    applyStimulus(32'h4000_0001);
    applyStimulus(32'h4000_0002);
    applyStimulus(32'h4000_0003);
    outSeen = 0;
    repeat (6) tick();
    checkOutput("basic_out_count", outSeen, 32'd3);
    checkOutput("basic_word_cnt", WORD_CNT, 32'd3);
    checkOutput("basic_err_cnt", {24'b0, ID_ERR_CNT}, 32'd0);

    $display("[TB] id filter");
    doClear();
    checkOutput("clr_word_cnt", WORD_CNT, 32'd0);
    applyStimulus(32'h4000_0010);
    applyStimulus(32'h5000_0011);
    applyStimulus(32'h4000_0012);
    outSeen = 0;
    repeat (6) tick();
    checkOutput("filter_out_count", outSeen, 32'd2);
    checkOutput("filter_word_cnt", WORD_CNT, 32'd2);
    checkOutput("filter_err_cnt", {24'b0, ID_ERR_CNT}, 32'd1);

    $display("[TB] full");
    doClear();
    OUT_FIFO_READ = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(32'h4000_0200 + i);
    repeat (20) tick();
    checkOutput("full_set", {31'b0, FULL}, 32'd1);
    checkOutput("full_no_pull", {31'b0, IN_FIFO_READ}, 32'd0);
    checkOutput("full_word_cnt", WORD_CNT, 32'd16);
    checkOutput("full_up_left", upQ.size(), 32'd4);
    OUT_FIFO_READ = 1'b1;
    tick();
    OUT_FIFO_READ = 1'b0;
    checkOutput("after_read_full", {31'b0, FULL}, 32'd0);
    checkOutput("after_read_pull", {31'b0, IN_FIFO_READ}, 32'd1);
    tick();
    checkOutput("refill_full", {31'b0, FULL}, 32'd1);
    checkOutput("refill_word_cnt", WORD_CNT, 32'd17);

    $display("[TB] wrap");
    doClear();
    for (int i = 0; i < 40; i++) applyStimulus(32'h4000_1000 + i);
    outSeen = 0;
    for (int c = 0; c < 300; c++) begin
      OUT_FIFO_READ = c[0];
      tick();
      if (upQ.size() == 0 && expQ.size() == 0) break;
    end
    checkOutput("wrap_out_count", outSeen, 32'd40);
    checkOutput("wrap_word_cnt", WORD_CNT, 32'd40);
    checkOutput("wrap_empty", {31'b0, OUT_FIFO_EMPTY}, 32'd1);

    $display("[TB] clear at occupancy 5");
    doClear();
    OUT_FIFO_READ = 1'b0;
    applyStimulus(32'h4000_0301);
    applyStimulus(32'h4000_0302);
    applyStimulus(32'h7000_0303);
    applyStimulus(32'h4000_0304);
    applyStimulus(32'h4000_0305);
    applyStimulus(32'h4000_0306);
    repeat (6) tick();
    checkOutput("occ5_word_cnt", WORD_CNT, 32'd5);
    checkOutput("occ5_err_cnt", {24'b0, ID_ERR_CNT}, 32'd1);
    CLEAR = 1'b1;
    OUT_FIFO_READ = 1'b1;
    tick();
    CLEAR = 1'b0;
    OUT_FIFO_READ = 1'b0;
    checkOutput("clear_empty", {31'b0, OUT_FIFO_EMPTY}, 32'd1);
    checkOutput("clear_word_cnt", WORD_CNT, 32'd0);
    checkOutput("clear_err_cnt", {24'b0, ID_ERR_CNT}, 32'd0);

    $display("[TB] reset mid-stream");
    OUT_FIFO_READ = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(32'h4000_0400 + i);
    repeat (3) tick();
    BUS_RST = 1'b1;
    #1;
    checkOutput("rst_mid_in_read", {31'b0, IN_FIFO_READ}, 32'd0);
    checkOutput("rst_mid_empty", {31'b0, OUT_FIFO_EMPTY}, 32'd1);
    checkOutput("rst_mid_word_cnt", WORD_CNT, 32'd0);
    expQ.delete();
    repeat (2) tick();
    BUS_RST = 1'b0;
    #1;
    checkOutput("rst_rel_empty", {31'b0, OUT_FIFO_EMPTY}, 32'd1);
    outSeen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (upQ.size() == 0 && expQ.size() == 0) break;
    end
    checkOutput("rst_restart_out", outSeen, 32'd7);
    checkOutput("rst_restart_cnt", WORD_CNT, 32'd7);

    $display("[TB] id error saturation");
    doClear();
    for (int i = 0; i < 300; i++) applyStimulus(32'h5000_0000 + i);
    repeat (310) tick();
    checkOutput("sat_err_cnt", {24'b0, ID_ERR_CNT}, 32'd255);
    checkOutput("sat_empty", {31'b0, OUT_FIFO_EMPTY}, 32'd1);
    checkOutput("sat_word_cnt", WORD_CNT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
